// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the DataMemory arbiter:
//   - arb_state_e : arbiter FSM state (free arbitration / locked burst)
//   - REQ_CPU, REQ_DBG : requester indices (processor LSU, debug/DMA port)
//   - idx_onehot() : converts a requester index into a one-hot grant vector
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  function automatic logic [1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin selector.
// Ports:
//   req[1:0] : request vector
//   last     : index of the requester that won most recently
//   gnt[1:0] : one-hot grant, or zero when nobody requests
// On a contest the requester that did not win last time is chosen.
// -----------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port DataMemory between requester 0 (CPU load/store) and
// requester 1 (debug/DMA). One access per cycle, round-robin on contention,
// optional locked bursts of up to MAX_LOCK consecutive grants.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req, lock, we_i     : per-requester request / burst-lock / write enable
//   addr0/1, wdata0/1   : per-requester address and write data
//   gnt                 : combinational one-hot grant for this cycle
//   rvalid, rdata       : registered read return (cycle after the read grant)
//   mem_we/mem_A/mem_WD : drive DataMemory; mem_RD is its combinational read
//   dbg_state_o         : current arbiter FSM state
//
// Handshake: req[i] is a valid that the requester holds (with its inputs
// stable) until it sees gnt[i] in the same cycle; gnt[i] acts as ready and the
// access completes at the rising edge ending that cycle. The arbiter never
// drops a pending request; it is serviced in a later cycle.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NBITS    = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       lock,
  input  logic [1:0]       we_i,
  input  logic [NBITS-1:0] addr0,
  input  logic [NBITS-1:0] addr1,
  input  logic [NBITS-1:0] wdata0,
  input  logic [NBITS-1:0] wdata1,
  output logic [1:0]       gnt,
  output logic [1:0]       rvalid,
  output logic [NBITS-1:0] rdata,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_A,
  output logic [NBITS-1:0] mem_WD,
  input  logic [NBITS-1:0] mem_RD,
  output arb_state_e       dbg_state_o
);

  localparam int                CW      = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0]     CNT_ONE = CW'(1);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [1:0]       rvalid_q;
  logic [NBITS-1:0] rdata_q;
  logic [NBITS-1:0] mem_a_q, mem_wd_q;

  logic [1:0]       rr_gnt;
  logic [1:0]       gnt_int;
  logic             any_gnt;
  logic             win;
  logic [1:0]       rd_grant;
  logic [CW-1:0]    cnt_inc;

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // Grant: suppressed during reset so no write can be issued in a reset cycle.
  // While locked the other requester is blocked even if the owner idles.
  always_comb begin
    gnt_int = 2'b00;
    if (!rst) begin
      if (state_q == ARB) begin
        gnt_int = rr_gnt;
      end else if (req[owner_q]) begin
        gnt_int = idx_onehot(owner_q);
      end
    end
  end

  assign any_gnt = |gnt_int;
  assign win     = gnt_int[1];

  // Datapath mux; with no grant the address/data hold their previous values.
  always_comb begin
    mem_we = 1'b0;
    mem_A  = mem_a_q;
    mem_WD = mem_wd_q;
    if (any_gnt) begin
      mem_we = we_i[win];
      mem_A  = win ? addr1  : addr0;
      mem_WD = win ? wdata1 : wdata0;
    end
  end

  assign rd_grant = (any_gnt && !we_i[win]) ? gnt_int : 2'b00;
  assign cnt_inc  = lock_cnt_q + CNT_ONE;

  // Next-state logic for the ARB/LOCKED FSM, burst counter and round-robin
  // history. last_q equals the owner throughout a lock, so whichever way the
  // lock ends the other requester wins the next contest.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ARB: begin
        if (any_gnt) begin
          last_d = win;
          if (lock[win] && (MAX_LOCK > 1)) begin
            state_d    = LOCKED;
            owner_d    = win;
            lock_cnt_d = CNT_ONE;
          end
        end
      end
      LOCKED: begin
        if (any_gnt && (lock_cnt_q != CNT_MAX)) begin
          lock_cnt_d = cnt_inc;
        end
        if (!req[owner_q] || !lock[owner_q] || (any_gnt && (cnt_inc == CNT_MAX))) begin
          state_d    = ARB;
          last_d     = owner_q;
          lock_cnt_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rvalid_q   <= 2'b00;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rd_grant;
      if (|rd_grant) begin
        rdata_q <= mem_RD;
      end
      mem_a_q    <= mem_A;
      mem_wd_q   <= mem_WD;
    end
  end

  assign gnt         = gnt_int;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MAXL = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic [1:0]  req, lock, we_i;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata, mem_A, mem_WD, mem_RD;
  logic        mem_we;
  arb_state_e  dbg_state;

  dmem_arbiter #(.NBITS(32), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we_i(we_i),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_we(mem_we), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD),
    .dbg_state_o(dbg_state)
  );

  // ---------------- DataMemory stand-in ----------------
  logic        mem_init;
  logic [31:0] mem [64];
  assign mem_RD = mem[mem_A[5:0]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (mem_we) begin
      mem[mem_A[5:0]] <= mem_WD;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [64];
  bit          m_locked;
  int          m_owner, m_cnt, m_last;
  logic [31:0] m_held_a, m_held_wd;
  logic [1:0]  exp_rvalid;
  logic [31:0] exp_rdata;
  logic [1:0]  obs_gnt, obs_rvalid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_owner    = 0;
    m_cnt      = 0;
    m_last     = 1;
    m_held_a   = '0;
    m_held_wd  = '0;
    exp_rvalid = 2'b00;
    exp_rdata  = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                      input logic [1:0] we, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    int          w;
    logic [1:0]  eg;
    logic [31:0] wa, wd;
    rst = r; req = rq; lock = lk; we_i = we;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    @(negedge clk);
    w = -1;
    if (!r) begin
      if (m_locked) begin
        if (rq[m_owner]) w = m_owner;
      end else if (rq == 2'b11) w = 1 - m_last;
      else if (rq == 2'b01) w = 0;
      else if (rq == 2'b10) w = 1;
    end
    eg = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    wa = (w == 1) ? a1 : a0;
    wd = (w == 1) ? d1 : d0;
    obs_gnt = gnt;
    obs_rvalid = rvalid;
    chk("gnt", {30'd0, gnt}, {30'd0, eg});
    chk("rvalid", {30'd0, rvalid}, {30'd0, exp_rvalid});
    chk("rdata", rdata, exp_rdata);
    chk("locked", {31'd0, dbg_state == LOCKED}, {31'd0, m_locked});
    chk("mem_we", {31'd0, mem_we}, {31'd0, (w >= 0) && we[w]});
    if (w >= 0) begin
      chk("mem_A", mem_A, wa);
      chk("mem_WD", mem_WD, wd);
    end else if (!r) begin
      chk("mem_A_hold", mem_A, m_held_a);
      chk("mem_WD_hold", mem_WD, m_held_wd);
    end
    // advance the model across the rising edge
    if (r) begin
      model_reset();
    end else begin
      exp_rvalid = 2'b00;
      if (w >= 0) begin
        m_held_a = wa;
        m_held_wd = wd;
        if (we[w]) ref_mem[wa[5:0]] = wd;
        else begin
          exp_rvalid = eg;
          exp_rdata  = ref_mem[wa[5:0]];
        end
      end
      if (m_locked) begin
        if (w >= 0) m_cnt++;
        if (!rq[m_owner] || !lk[m_owner] || m_cnt == MAXL) begin
          m_locked = 1'b0;
          m_last   = m_owner;
          m_cnt    = 0;
        end
      end else if (w >= 0) begin
        m_last = w;
        if (lk[w] && MAXL > 1) begin
          m_locked = 1'b1;
          m_owner  = w;
          m_cnt    = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic reset_cycle();
    step(1'b1, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int run1;
    bit seen_r1, done;
    logic [1:0] order [4];
    rst = 1'b1; mem_init = 1'b1;
    req = '0; lock = '0; we_i = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | i;
    repeat (2) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst = 1'b0;
    model_reset();

    // reset state
    idle();
    chk("reset_mem_A", mem_A, 32'd0);
    chk("reset_rdata", rdata, 32'd0);

    // single requester write then read
    step(1'b0, 2'b01, 2'b00, 2'b01, 32'd1, 32'd0, 32'hDEAD_BEEF, 32'd0);
    chk("single_wr_gnt", {30'd0, obs_gnt}, 32'd1);
    step(1'b0, 2'b01, 2'b00, 2'b00, 32'd1, 32'd0, 32'd0, 32'd0);
    chk("single_rd_gnt", {30'd0, obs_gnt}, 32'd1);
    idle();
    chk("single_rvalid", {30'd0, obs_rvalid}, 32'd1);
    chk("single_rdata", rdata, 32'hDEAD_BEEF);

    // contention after reset
    reset_cycle();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b11, 2'b00, 2'b00, 32'd2, 32'd3, 32'd0, 32'd0);
      order[i] = obs_gnt;
    end
    chk("contend_order", {24'd0, order[0], order[1], order[2], order[3]}, 32'b01100110);
    idle();

    // lock burst: requester 1 holds req+lock while requester 0 requests
    run1 = 0; seen_r1 = 0; done = 0;
    for (int i = 0; i < 24 && !done; i++) begin
      step(1'b0, 2'b11, 2'b10, 2'b00, 32'd4, 32'd6, 32'd0, 32'd0);
      if (obs_gnt == 2'b10) begin seen_r1 = 1; run1++; end
      else if (seen_r1 && obs_gnt == 2'b01) done = 1;
    end
    chk("lock_burst_len", run1, MAXL);
    chk("lock_burst_release", {31'd0, done}, 32'd1);
    idle();

    // early unlock by requester 0 while requester 1 waits
    step(1'b0, 2'b01, 2'b01, 2'b00, 32'd7, 32'd8, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'b11, 2'b01, 2'b00, 32'd7, 32'd8, 32'd0, 32'd0);
    step(1'b0, 2'b11, 2'b00, 2'b00, 32'd7, 32'd8, 32'd0, 32'd0);
    step(1'b0, 2'b11, 2'b00, 2'b00, 32'd7, 32'd8, 32'd0, 32'd0);
    chk("early_unlock_gnt", {30'd0, obs_gnt}, 32'd2);
    idle();

    // write collision on address 5
    reset_cycle();
    step(1'b0, 2'b11, 2'b00, 2'b11, 32'd5, 32'd5, 32'h1111_1111, 32'h2222_2222);
    chk("collide_first", {30'd0, obs_gnt}, 32'd1);
    step(1'b0, 2'b10, 2'b00, 2'b10, 32'd5, 32'd5, 32'h1111_1111, 32'h2222_2222);
    chk("collide_second", {30'd0, obs_gnt}, 32'd2);
    step(1'b0, 2'b01, 2'b00, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0);
    idle();
    chk("collide_final", rdata, 32'h2222_2222);

    // reset during the 4th locked grant of requester 1 (reads pending)
    step(1'b0, 2'b10, 2'b10, 2'b00, 32'd0, 32'd9, 32'd0, 32'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 2'b11, 2'b10, 2'b00, 32'd2, 32'd9, 32'd0, 32'd0);
    step(1'b1, 2'b11, 2'b10, 2'b00, 32'd2, 32'd9, 32'd0, 32'd0);
    idle();
    chk("rst_lock_rvalid", {30'd0, obs_rvalid}, 32'd0);
    chk("rst_lock_rdata", rdata, 32'd0);
    chk("rst_lock_mem_A", mem_A, 32'd0);
    chk("rst_lock_mem_WD", mem_WD, 32'd0);
    step(1'b0, 2'b11, 2'b00, 2'b00, 32'd2, 32'd9, 32'd0, 32'd0);
    chk("rst_lock_first_win", {30'd0, obs_gnt}, 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)), $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port `DataMemory` between the processor load/store path (requester 0) and a debug/DMA port (requester 1). It sits directly in front of `DataMemory` and owns its `we`, `A` and `WD` inputs. It grants one access per cycle using round-robin priority, supports short locked bursts, and registers read data back to the winning requester.

## Interface
- `NBITS`, 32, data and address width (matches `DataMemory`)
- `MAX_LOCK`, 8, maximum consecutive grants to one locked requester before forced release (≥1)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req[1:0]`  in  2  access request per requester
- `lock[1:0]`  in  2  requester asks to keep ownership next cycle (valid only with its `req`)
- `we_i[1:0]`  in  2  write enable per requester
- `addr0`, `addr1`  in  NBITS  address per requester
- `wdata0`, `wdata1`  in  NBITS  write data per requester
- `gnt[1:0]`  out  2  one-hot or zero; combinational grant for the current cycle
- `rvalid[1:0]`  out  2  registered; read data valid for the requester granted a read last cycle
- `rdata`  out  NBITS  registered read data, shared by both requesters
- `mem_we`  out  1  to `DataMemory.we`
- `mem_A`  out  NBITS  to `DataMemory.A`
- `mem_WD`  out  NBITS  to `DataMemory.WD`
- `mem_RD`  in  NBITS  from `DataMemory.RD` (combinational read)

## Operation
- The FSM has two states: `ARB` (free arbitration) and `LOCKED` (the owner is held in `owner`).
- In `ARB`:
  - If only one requester has `req` set, it wins.
  - If both have `req` set, the requester ≠ `last` wins (round-robin).
  - The winner's `we_i`, address and write data are muxed onto `mem_*`.
  - `last` updates to the winner.
- `ARB → LOCKED` when the winner has both `req` and `lock` set and `MAX_LOCK > 1`. `owner` is set to the winner and `lock_cnt` is set to 1.
- In `LOCKED`:
  - The owner is granted whenever its `req` is set. The other requester is blocked even if the owner is idle that cycle.
  - `lock_cnt` increments on each granted cycle.
- `LOCKED → ARB` when any of the following holds:
  - the owner drops `lock`;
  - the owner drops `req`;
  - `lock_cnt` reaches `MAX_LOCK` on a granted cycle.
  On a forced release, `last` is set to the owner, so the other requester wins the next contested cycle.
- With no grant: `mem_we`=0, and `mem_A`/`mem_WD` hold their last values (do-not-care, but stable).
- Writes commit in `DataMemory` at the end of the grant cycle.
- Reads: `mem_RD` is captured into `rdata` at the end of the grant cycle, and the granted bit of `rvalid` is set for exactly one cycle.
- A write grant never asserts `rvalid`.
- `lock` without `req` is ignored.

## Timing
- Grant latency is 0 cycles: `gnt` is valid in the same cycle as `req`, and the requester must hold its inputs stable throughout that cycle.
- A requester without `gnt` keeps `req` asserted; the request is serviced in a later cycle and is never dropped by the arbiter.
- Read latency: `rvalid`/`rdata` appear in cycle N+1 for a grant in cycle N. Back-to-back reads produce `rvalid` every cycle.
- Reset values:
  - outputs: `gnt`=0, `rvalid`=0, `rdata`=0, `mem_we`=0, `mem_A`=0, `mem_WD`=0;
  - state: FSM=`ARB`, `last`=1 (requester 0 wins the first contest), `lock_cnt`=0.
- If `rst` is asserted during a lock or with an `rvalid` pending, the next cycle shows reset values. No write is issued in a reset cycle.
- Simultaneous writes to the same address: only the winner writes. The loser writes later and overwrites.
- `lock_cnt` is `$clog2(MAX_LOCK+1)` bits wide and never wraps.
- With `MAX_LOCK`=1 the arbiter never enters `LOCKED`.

## Structure
- Shared package `dmem_arb_pkg`: the FSM state enum (`ARB`, `LOCKED`) and requester-index constants `REQ_CPU`=0, `REQ_DBG`=1.
- One sub-module, `rr_pick2`: combinational 2-way round-robin selector with inputs `req[1:0]` and `last`, and a one-hot grant output.
- Datapath mux, FSM, counter and read-return register all live in `dmem_arbiter`.
- Top-level tests instantiate `dmem_arbiter` and `DataMemory` together.

## Test plan
- Single requester: write `DEADBEEF` to address 1 via requester 0, then read it. Expect `gnt`=01 in both cycles, then `rvalid`=01 with `rdata`=`DEADBEEF` one cycle after the read grant.
- Contention after reset: both requesters read addresses 2 and 3 continuously. Expect grant order 01, 10, 01, 10, and each `rvalid` to match the previous cycle's grant.
- Lock burst with `MAX_LOCK`=8: requester 1 holds `req`+`lock` while requester 0 requests. Expect exactly 8 grants to requester 1, then `gnt`=01.
- Early unlock: requester 0 drops `lock` after 3 locked grants while requester 1 is waiting. Expect `gnt`=10 in the next cycle.
- Write collision: both requesters write address 5 (`11111111` and `22222222`) in the same cycle after reset. Expect requester 0 to commit first, requester 1 next, and a final read to return `22222222`.
- Reset mid-lock: assert `rst` during the 4th locked grant. Expect all outputs zero the next cycle, then requester 0 to win the first contest after reset.
